tlc_lamp_monitor: RTL

Passive checker that sits on the lamp outputs of the traffic light controller (red/yellow/green plus the pass override) and decodes them back into a phase stream. It verifies that every pattern and phase transition is legal, measures dwell time per phase, and latches a coded fault until software clears it. It is the observing end of the controller's lamp interface, used in the safety/conflict-monitor path and as a bench scoreboard.

---
 rtl/tlc_lamp_monitor_if.sv | 10 +
 rtl/tlc_lamp_monitor.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/tlc_lamp_monitor_if.sv
// Lamp bus between the traffic light controller (master) and its observers (slave).
interface tlc_lamp_monitor_if;
  logic red;
  logic yellow;
  logic green;
  logic pass;

  modport master (output red, output yellow, output green, output pass);
  modport slave  (input  red, input  yellow, input  green, input  pass);
endinterface

// File: rtl/tlc_lamp_monitor.sv
// Passive lamp monitor: decodes R/Y/G/pass into phases, checks legality and dwell, latches faults.
// Build option: define TLC_MON_DWELL_CHECK_EN to enable the dwell-short/dwell-long fault checks.
module tlc_lamp_monitor #(
  parameter int unsigned DWELL_W   = 8,
  parameter int unsigned MIN_DWELL = 2,
  parameter int unsigned MAX_DWELL = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  tlc_lamp_monitor_if.slave      lamps,
  input  logic                   clear_fault,
  output logic [1:0]             phase,
  output logic                   phase_valid,
  output logic                   phase_change,
  output logic [DWELL_W-1:0]     dwell,
  output logic                   fault,
  output logic [2:0]             fault_code,
  output logic [7:0]             fault_count
);

`ifdef TLC_MON_DWELL_CHECK_EN
  localparam bit DWELL_CHECK_EN = 1'b1;
`else
  localparam bit DWELL_CHECK_EN = 1'b0;
`endif

  localparam logic [DWELL_W-1:0] MIN_D = DWELL_W'(MIN_DWELL);
  localparam logic [DWELL_W-1:0] MAX_D = DWELL_W'(MAX_DWELL);

  typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;
  typedef enum logic [1:0] {PH_R = 2'b00, PH_RY = 2'b01, PH_G = 2'b10, PH_GY = 2'b11} phase_t;
  typedef enum logic [2:0] {
    FC_NONE = 3'd0, FC_PATTERN = 3'd1, FC_TRANSITION = 3'd2, FC_SHORT = 3'd3, FC_LONG = 3'd4
  } fcode_t;

  logic s_red_q, s_yellow_q, s_green_q, s_pass_q;

  state_t               state_q, state_d;
  phase_t               phase_q, phase_d;
  logic                 phase_valid_q, phase_valid_d;
  logic                 phase_change_q, phase_change_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 fault_q, fault_d;
  fcode_t               fault_code_q, fault_code_d;
  logic [7:0]           fault_count_q, fault_count_d;

  logic                 pat_legal;
  phase_t               pat_phase;
  logic [1:0]           seq_next;
  logic                 is_hold, legal_tr, dwell_short, dwell_long;
  logic [DWELL_W-1:0]   dwell_inc;

  // Anything outside the four lamp codes, X/Z included, falls to default.
  always_comb begin
    pat_legal = 1'b1;
    pat_phase = PH_R;
    case ({s_red_q, s_yellow_q, s_green_q})
      3'b100:  pat_phase = PH_R;
      3'b110:  pat_phase = PH_RY;
      3'b001:  pat_phase = PH_G;
      3'b011:  pat_phase = PH_GY;
      default: pat_legal = 1'b0;
    endcase
  end

  // The normal cycle R->RY->G->GY->R is simply phase+1 modulo 4.
  always_comb begin
    seq_next    = phase_q + 2'd1;
    is_hold     = (pat_phase == phase_q);
    legal_tr    = is_hold || (pat_phase == phase_t'(seq_next)) || (s_pass_q && (pat_phase == PH_G));
    dwell_inc   = (dwell_q == '1) ? dwell_q : dwell_q + 1'b1;
    dwell_short = DWELL_CHECK_EN && !is_hold && !s_pass_q && (dwell_q < MIN_D);
    dwell_long  = DWELL_CHECK_EN && is_hold && (dwell_inc == MAX_D);
  end

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    phase_change_d = 1'b0;
    dwell_d        = dwell_q;
    fault_d        = fault_q;
    fault_code_d   = fault_code_q;
    fault_count_d  = fault_count_q;

    case (state_q)
      SYNC: begin
        if (pat_legal) begin
          state_d = TRACK;
          phase_d = pat_phase;
          dwell_d = DWELL_W'(1);
        end
      end
      TRACK: begin
        if (!pat_legal)        fault_code_d = FC_PATTERN;
        else if (!legal_tr)    fault_code_d = FC_TRANSITION;
        else if (dwell_short)  fault_code_d = FC_SHORT;
        else if (is_hold) begin
          dwell_d = dwell_inc;
          if (dwell_long) fault_code_d = FC_LONG;
        end else begin
          phase_d        = pat_phase;
          dwell_d        = DWELL_W'(1);
          phase_change_d = 1'b1;
        end
        if (fault_code_d != FC_NONE) begin
          state_d       = FAULT;
          fault_d       = 1'b1;
          fault_count_d = (fault_count_q == 8'hFF) ? fault_count_q : fault_count_q + 8'd1;
        end
      end
      FAULT: begin
        if (clear_fault) begin
          state_d      = SYNC;
          fault_d      = 1'b0;
          fault_code_d = FC_NONE;
        end
      end
      default: state_d = SYNC;
    endcase

    phase_valid_d = (state_d == TRACK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_red_q        <= 1'b0;
      s_yellow_q     <= 1'b0;
      s_green_q      <= 1'b0;
      s_pass_q       <= 1'b0;
      state_q        <= SYNC;
      phase_q        <= PH_R;
      phase_valid_q  <= 1'b0;
      phase_change_q <= 1'b0;
      dwell_q        <= '0;
      fault_q        <= 1'b0;
      fault_code_q   <= FC_NONE;
      fault_count_q  <= '0;
    end else begin
      s_red_q        <= lamps.red;
      s_yellow_q     <= lamps.yellow;
      s_green_q      <= lamps.green;
      s_pass_q       <= lamps.pass;
      state_q        <= state_d;
      phase_q        <= phase_d;
      phase_valid_q  <= phase_valid_d;
      phase_change_q <= phase_change_d;
      dwell_q        <= dwell_d;
      fault_q        <= fault_d;
      fault_code_q   <= fault_code_d;
      fault_count_q  <= fault_count_d;
    end
  end

  assign phase        = phase_q;
  assign phase_valid  = phase_valid_q;
  assign phase_change = phase_change_q;
  assign dwell        = dwell_q;
  assign fault        = fault_q;
  assign fault_code   = fault_code_q;
  assign fault_count  = fault_count_q;

endmodule
